// File: rtl/ahb_pkg.sv
// AHB-Lite code points, data-phase record and FSM state type shared by the SRAM slave
// and its decode logic.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Controls captured at the address phase and held through the data phase.
    typedef struct packed {
        logic       valid;
        logic       write;
        logic       err;
        logic [3:0] mask;
    } dphase_t;

    function automatic logic is_active(input logic [1:0] htrans);
        logic act;
        act = 1'b0;
        case (htrans)
            HTRANS_IDLE, HTRANS_BUSY: act = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/ahb_lane_decode.sv
// Little-endian byte-lane mask and size/alignment error decode for one address phase.
module ahb_lane_decode
    import ahb_pkg::*;
(
    input  logic [1:0] haddr_lo,
    input  logic [2:0] hsize,
    output logic [3:0] mask,
    output logic       misaligned
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mask       = 4'b0000;
        misaligned = 1'b0;
        case (hsize)
            HSIZE_BYTE: mask = 4'b0001 << haddr_lo;
            HSIZE_HALF: begin
                mask       = haddr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = haddr_lo[0];
            end
            HSIZE_WORD: begin
                mask       = 4'b1111;
                misaligned = (haddr_lo != 2'b00);
            end
            // Sizes wider than a word cannot be served by a 32-bit slave.
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: pipelined address/data phases, programmable wait states and
// two-cycle ERROR responses for misaligned, oversized or out-of-range transfers.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [33:0] BYTE_SPAN = 34'(MEM_WORDS) * 34'd4;

    state_t      state;
    logic [1:0]  wait_cnt;
    dphase_t     dp;
    logic [AW-1:0] dp_word;

    logic [3:0]  lane_mask;
    logic        misaligned;
    logic        out_of_range;
    logic        addr_err;
    logic        accept;
    logic        wr_en;

    logic [31:0] mem [MEM_WORDS];

    ahb_lane_decode u_lane_decode (
        .haddr_lo   (HADDR[1:0]),
        .hsize      (HSIZE),
        .mask       (lane_mask),
        .misaligned (misaligned)
    );

    assign out_of_range = ({2'b00, HADDR} >= BYTE_SPAN);
    assign addr_err     = misaligned || out_of_range;
    assign accept       = HSEL && HREADY && is_active(HTRANS);

    // A write lands on the edge that ends its completion cycle, so a read accepted on
    // that same edge already sees the new data.
    assign wr_en = (state == ST_IDLE) && dp.valid && dp.write && !dp.err && !HRESET;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            dp        <= '0;
            dp_word   <= '0;
        end else begin
            case (state)
                // Both states present HREADYOUT=1, so each may start the next transfer.
                ST_IDLE, ST_ERR2: begin
                    dp.valid <= accept;
                    if (accept) begin
                        dp.write <= HWRITE;
                        dp.err   <= addr_err;
                        dp.mask  <= lane_mask;
                        dp_word  <= HADDR[AW+1:2];
                        if (addr_err) begin
                            state     <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state     <= ST_WAIT;
                            wait_cnt  <= 2'(WAIT_STATES);
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_OKAY;
                        end else begin
                            state     <= ST_IDLE;
                            HREADYOUT <= 1'b1;
                            HRESP     <= HRESP_OKAY;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 2'd1) begin
                        state     <= ST_IDLE;
                        wait_cnt  <= '0;
                        HREADYOUT <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                end
                default: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                    dp.valid  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: storage has no reset; contents survive HRESET and only the control path is cleared.
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (dp.mask[i]) begin
                    mem[dp_word][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        if (dp.valid && !dp.write && !dp.err) begin
            HRDATA = mem[dp_word];
        end
    end

    // Error responses are always exactly ERR1 followed by ERR2.
    assert property (@(posedge HCLK) disable iff (HRESET)
        (state == ST_ERR1) |=> (state == ST_ERR2 && HRESP == HRESP_ERROR && HREADYOUT));

    assert property (@(posedge HCLK) !(wr_en && dp.err));

endmodule
